// File: rtl/pingpong_buffer_sequencer.sv
// Ping-pong controller for two message FIFOs: upstream fills one buffer while
// downstream drains the other. It generates the FIFO enables and the read-select; it holds no data.
module pingpong_buffer_sequencer #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               wr_last,
  output logic               wr_ready,
  input  logic               rd_en,
  output logic               rd_ready,
  output logic               rd_last,
  output logic               rd_sel,
  input  logic               empty_buff1,
  input  logic               empty_buff2,
  input  logic               full_buff1,
  input  logic               full_buff2,
  output logic               wr_en_buff1,
  output logic               wr_en_buff2,
  output logic               rd_en_buff1,
  output logic               rd_en_buff2,
  output logic               empty,
  output logic               full,
  output logic               overflow_err,
  output logic               underflow_err,
  output logic               sync_err,
  output logic [3:0]         dbg_state,
  output logic [2*CNT_W-1:0] dbg_len
);

  // Handshake: a write transfers on wr_en & wr_ready, and a read transfers on
  // rd_en & rd_ready, in the same cycle. Requests made while not ready are
  // dropped and latch the matching sticky error.

  typedef enum logic [1:0] {FREE = 2'd0, FILL = 2'd1, READY = 2'd2, DRAIN = 2'd3} buf_state_e;

  buf_state_e       state_q  [2];
  buf_state_e       state_d  [2];
  logic [CNT_W-1:0] wr_cnt_q [2];
  logic [CNT_W-1:0] wr_cnt_d [2];
  logic [CNT_W-1:0] len_q    [2];
  logic [CNT_W-1:0] len_d    [2];
  logic [CNT_W-1:0] rem_q    [2];
  logic [CNT_W-1:0] rem_d    [2];
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic             wr_acc, rd_acc, wr_close;
  logic [CNT_W-1:0] wr_cnt_inc;
  logic [1:0]       full_in, empty_in, sync_hit;

  assign full_in  = {full_buff2, full_buff1};
  assign empty_in = {empty_buff2, empty_buff1};

  assign wr_ready   = (state_q[wr_sel_q] == FREE) || (state_q[wr_sel_q] == FILL);
  assign rd_ready   = (state_q[rd_sel_q] == READY) || (state_q[rd_sel_q] == DRAIN);
  assign rd_last    = rd_ready && (rem_q[rd_sel_q] == CNT_W'(1));
  assign rd_sel     = rd_sel_q;
  // Gating with rst keeps the FIFO enables quiet while reset is asserted.
  assign wr_acc     = wr_en && wr_ready && !rst;
  assign rd_acc     = rd_en && rd_ready && !rst;
  assign wr_cnt_inc = wr_cnt_q[wr_sel_q] + CNT_W'(1);
  assign wr_close   = wr_last || (wr_cnt_inc == CNT_W'(ENTRIES));

  assign wr_en_buff1 = wr_acc && !wr_sel_q;
  assign wr_en_buff2 = wr_acc &&  wr_sel_q;
  assign rd_en_buff1 = rd_acc && !rd_sel_q;
  assign rd_en_buff2 = rd_acc &&  rd_sel_q;

  assign empty = (state_q[0] == FREE) && (state_q[1] == FREE);
  assign full  = (state_q[0] != FREE) && (state_q[0] != FILL) &&
                 (state_q[1] != FREE) && (state_q[1] != FILL);

  assign dbg_state = {state_q[1], state_q[0]};
  assign dbg_len   = {len_q[1], len_q[0]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_hit[i] = (full_in[i] && ((state_q[i] == FREE) || (state_q[i] == FILL)) &&
                     (wr_cnt_q[i] < CNT_W'(ENTRIES))) ||
                    (empty_in[i] && ((state_q[i] == READY) || (state_q[i] == DRAIN)));
    end
  end

  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      wr_cnt_d[i] = wr_cnt_q[i];
      len_d[i]    = len_q[i];
      rem_d[i]    = rem_q[i];
    end
    for (int i = 0; i < 2; i++) begin
      if (wr_acc && (wr_sel_q == i[0])) begin
        if (wr_close) begin
          state_d[i]  = READY;
          len_d[i]    = wr_cnt_inc;
          rem_d[i]    = wr_cnt_inc;
          wr_cnt_d[i] = '0;
          wr_sel_d    = ~wr_sel_q;
        end else begin
          state_d[i]  = FILL;
          wr_cnt_d[i] = wr_cnt_inc;
        end
      end
      // FILL and DRAIN are exclusive, so the read below never hits the written buffer.
      if (rd_acc && (rd_sel_q == i[0])) begin
        if (rem_q[i] == CNT_W'(1)) begin
          state_d[i] = FREE;
          rem_d[i]   = '0;
          rd_sel_d   = ~rd_sel_q;
        end else begin
          state_d[i] = DRAIN;
          rem_d[i]   = rem_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= FREE;
        wr_cnt_q[i] <= '0;
        len_q[i]    <= '0;
        rem_q[i]    <= '0;
      end
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= state_d[i];
        wr_cnt_q[i] <= wr_cnt_d[i];
        len_q[i]    <= len_d[i];
        rem_q[i]    <= rem_d[i];
      end
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      if (wr_en && !wr_ready) overflow_err  <= 1'b1;
      if (rd_en && !rd_ready) underflow_err <= 1'b1;
      if (|sync_hit)          sync_err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pingpong_buffer_sequencer.sv
// Directed bench for pingpong_buffer_sequencer with ENTRIES=4 and a simple
// occupancy model standing in for the two FIFOs.
module tb_pingpong_buffer_sequencer;

  localparam int ENTRIES = 4;
  localparam int CNT_W   = $clog2(ENTRIES + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0, wr_last = 1'b0, rd_en = 1'b0;
  logic wr_ready, rd_ready, rd_last, rd_sel;
  logic empty_buff1, empty_buff2, full_buff1, full_buff2;
  logic wr_en_buff1, wr_en_buff2, rd_en_buff1, rd_en_buff2;
  logic empty, full, overflow_err, underflow_err, sync_err;
  logic [3:0]         dbg_state;
  logic [2*CNT_W-1:0] dbg_len;
  logic force_empty1 = 1'b0;

  int occ1, occ2;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pingpong_buffer_sequencer #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_ready(rd_ready), .rd_last(rd_last), .rd_sel(rd_sel),
    .empty_buff1(empty_buff1), .empty_buff2(empty_buff2),
    .full_buff1(full_buff1), .full_buff2(full_buff2),
    .wr_en_buff1(wr_en_buff1), .wr_en_buff2(wr_en_buff2),
    .rd_en_buff1(rd_en_buff1), .rd_en_buff2(rd_en_buff2),
    .empty(empty), .full(full),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .sync_err(sync_err),
    .dbg_state(dbg_state), .dbg_len(dbg_len)
  );

  // FIFO occupancy model driving the empty/full flags
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      occ1 <= 0;
      occ2 <= 0;
    end else begin
      occ1 <= occ1 + int'(wr_en_buff1) - int'(rd_en_buff1);
      occ2 <= occ2 + int'(wr_en_buff2) - int'(rd_en_buff2);
    end
  end
  assign empty_buff1 = (occ1 == 0) || force_empty1;
  assign empty_buff2 = (occ2 == 0);
  assign full_buff1  = (occ1 == ENTRIES);
  assign full_buff2  = (occ2 == ENTRIES);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
    check({tag, "_rd_last"},  32'(rd_last),  32'd0);
    check({tag, "_empty"},    32'(empty),    32'd1);
    check({tag, "_full"},     32'(full),     32'd0);
    check({tag, "_rd_sel"},   32'(rd_sel),   32'd0);
    check({tag, "_enables"},  32'({wr_en_buff1, wr_en_buff2, rd_en_buff1, rd_en_buff2}), 32'd0);
    check({tag, "_errs"},     32'({overflow_err, underflow_err, sync_err}), 32'd0);
  endtask

  initial begin
    do_reset();
    check_reset_outputs("rst");
    check("rst_state", 32'(dbg_state), 32'h0);

    // Four writes to buff1 close the block on the count boundary.
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1;
      #1;
      check($sformatf("p1_wen1_%0d", k), 32'({wr_en_buff1, wr_en_buff2}), 32'b10);
      tick();
    end
    wr_en = 1'b0;
    #1;
    check("p1_rd_ready", 32'(rd_ready), 32'd1);
    check("p1_state",    32'(dbg_state), 32'h2);
    check("p1_empty",    32'(empty), 32'd0);
    check("p1_len",      32'(dbg_len[CNT_W-1:0]), 32'd4);

    // Drain buff1 while filling buff2.
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; rd_en = 1'b1;
      #1;
      check($sformatf("p2_en_%0d", k), 32'({wr_en_buff1, wr_en_buff2, rd_en_buff1, rd_en_buff2}), 32'b0110);
      check($sformatf("p2_last_%0d", k), 32'(rd_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check("p2_rd_sel", 32'(rd_sel), 32'd1);
    check("p2_state",  32'(dbg_state), 32'h8);
    check("p2_errs",   32'({overflow_err, underflow_err, sync_err}), 32'd0);

    // Drain buff2.
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      #1;
      check($sformatf("p3_ren2_%0d", k), 32'({rd_en_buff1, rd_en_buff2}), 32'b01);
      check($sformatf("p3_last_%0d", k), 32'(rd_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    rd_en = 1'b0;
    #1;
    check("p3_empty",  32'(empty), 32'd1);
    check("p3_rd_sel", 32'(rd_sel), 32'd0);

    // Short block: two words, the second marked last.
    for (int k = 0; k < 2; k++) begin
      wr_en = 1'b1; wr_last = (k == 1);
      #1;
      check($sformatf("p4_wen1_%0d", k), 32'({wr_en_buff1, wr_en_buff2}), 32'b10);
      tick();
    end
    wr_en = 1'b0; wr_last = 1'b0;
    #1;
    check("p4_len",      32'(dbg_len[CNT_W-1:0]), 32'd2);
    check("p4_rd_ready", 32'(rd_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      rd_en = 1'b1;
      #1;
      check($sformatf("p4_ren1_%0d", k), 32'({rd_en_buff1, rd_en_buff2}), 32'b10);
      check($sformatf("p4_last_%0d", k), 32'(rd_last), (k == 1) ? 32'd1 : 32'd0);
      tick();
    end
    rd_en = 1'b0;
    #1;
    check("p4_done_rd_ready", 32'(rd_ready), 32'd0);

    // Fill both buffers: buff2 is next in line, then buff1.
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1;
      #1;
      check($sformatf("p5_wen_%0d", k), 32'({wr_en_buff1, wr_en_buff2}), (k < 4) ? 32'b01 : 32'b10);
      tick();
    end
    wr_en = 1'b0;
    #1;
    check("p5_full",     32'(full), 32'd1);
    check("p5_wr_ready", 32'(wr_ready), 32'd0);
    check("p5_state",    32'(dbg_state), 32'hA);
    wr_en = 1'b1;
    #1;
    check("p5_ovf_wen", 32'({wr_en_buff1, wr_en_buff2}), 32'b00);
    tick();
    wr_en = 1'b0;
    #1;
    check("p5_ovf_err", 32'(overflow_err), 32'd1);

    // Older block (buff2) is served first; stop with rem=2.
    for (int k = 0; k < 2; k++) begin
      rd_en = 1'b1;
      #1;
      check($sformatf("p5_ren2_%0d", k), 32'({rd_en_buff1, rd_en_buff2}), 32'b01);
      tick();
    end

    // Asynchronous reset mid-drain with both requests still asserted.
    wr_en = 1'b1; rd_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b0;
    #1;
    wr_en = 1'b1;
    #1;
    check("post_wen1", 32'({wr_en_buff1, wr_en_buff2}), 32'b10);
    wr_en = 1'b0;

    // Underflow from a clean reset.
    do_reset();
    rd_en = 1'b1;
    #1;
    check("uf_ren", 32'({rd_en_buff1, rd_en_buff2}), 32'b00);
    tick();
    rd_en = 1'b0;
    #1;
    check("uf_err", 32'(underflow_err), 32'd1);

    // Single-word block, then a FIFO flag that contradicts READY.
    wr_en = 1'b1; wr_last = 1'b1;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
    #1;
    check("sync_state", 32'(dbg_state), 32'h2);
    check("sync_pre",   32'(sync_err), 32'd0);
    force_empty1 = 1'b1;
    tick();
    force_empty1 = 1'b0;
    #1;
    check("sync_err", 32'(sync_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
